// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter FSM states
// for the instruction RAM arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RDATA
    } arb_state_e;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] t);
        logic act;
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE,   HTRANS_BUSY: act = 1'b0;
            default:                    act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_slave_capture.sv
// Per-port AHB-Lite slave front end: accepts one transfer,
// checks it, holds it pending and sequences the response.
module ahb_slave_capture
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    output logic [31:0]       hrdata,
    output logic              hready,
    output logic              hresp,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              write_o,
    input  logic              done_i,
    input  logic              load_i,
    input  logic [31:0]       rdata_i
);

    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              hready_q, hready_d;
    logic              hresp_q, hresp_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic              accept;
    logic              bad;

    assign accept = hready_q & htrans_active(htrans);
    assign bad    = (haddr[31:ADDR_W+2] != '0)
                  | (hsize != HSIZE_WORD)
                  | (haddr[1:0] != 2'b00);

    // Accept, error sequencing and completion of the buffered transfer.
    always_comb begin
        pend_d   = pend_q;
        err_d    = err_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        hrdata_d = hrdata_q;
        addr_d   = addr_q;
        write_d  = write_q;
        if (load_i) hrdata_d = rdata_i;
        if (accept) begin
            pend_d   = ~bad;
            err_d    = bad;
            hready_d = 1'b0;
            hresp_d  = bad ? HRESP_ERROR : HRESP_OKAY;
            addr_d   = haddr[ADDR_W+1:2];
            write_d  = hwrite;
        end else if (err_q) begin
            err_d    = 1'b0;
            hready_d = 1'b1;
            hresp_d  = HRESP_ERROR;
        end else if (done_i) begin
            pend_d   = 1'b0;
            hready_d = 1'b1;
            hresp_d  = HRESP_OKAY;
        end else if (hready_q) begin
            hresp_d  = HRESP_OKAY;
        end
    end

    // Port state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            err_q    <= err_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
        end
    end

    assign hrdata  = hrdata_q;
    assign hready  = hready_q;
    assign hresp   = hresp_q;
    assign req_o   = pend_q;
    assign addr_o  = addr_q;
    assign write_o = write_q;

endmodule

// File: rtl/imem_arbiter.sv
// Instruction RAM arbiter between SPI loader and core fetch.
// IMEM_ARB_RR_EN selects round-robin; default is SPI priority.
module imem_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       spi_haddr,
    input  logic              spi_hwrite,
    input  logic [2:0]        spi_hsize,
    input  logic [1:0]        spi_htrans,
    input  logic [31:0]       spi_hwdata,
    output logic [31:0]       spi_hrdata,
    output logic              spi_hready,
    output logic              spi_hresp,
    input  logic [31:0]       imem_haddr,
    input  logic              imem_hwrite,
    input  logic [2:0]        imem_hsize,
    input  logic [1:0]        imem_htrans,
    input  logic [31:0]       imem_hwdata,
    output logic [31:0]       imem_hrdata,
    output logic              imem_hready,
    output logic              imem_hresp,
    input  logic [31:0]       inst_read,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_write,
    output logic              inst_rwn
);

    logic              spi_req, core_req;
    logic [ADDR_W-1:0] spi_addr, core_addr;
    logic              spi_wr, core_wr;
    logic              done, load, pick_core;

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rwn_q, rwn_d;
`ifdef IMEM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    ahb_slave_capture #(.ADDR_W(ADDR_W)) u_spi (
        .clk(clk), .reset(reset),
        .haddr(spi_haddr), .hwrite(spi_hwrite),
        .hsize(spi_hsize), .htrans(spi_htrans),
        .hrdata(spi_hrdata), .hready(spi_hready),
        .hresp(spi_hresp),
        .req_o(spi_req), .addr_o(spi_addr), .write_o(spi_wr),
        .done_i(done & ~gnt_q), .load_i(load & ~gnt_q),
        .rdata_i(inst_read)
    );

    ahb_slave_capture #(.ADDR_W(ADDR_W)) u_core (
        .clk(clk), .reset(reset),
        .haddr(imem_haddr), .hwrite(imem_hwrite),
        .hsize(imem_hsize), .htrans(imem_htrans),
        .hrdata(imem_hrdata), .hready(imem_hready),
        .hresp(imem_hresp),
        .req_o(core_req), .addr_o(core_addr), .write_o(core_wr),
        .done_i(done & gnt_q), .load_i(load & gnt_q),
        .rdata_i(inst_read)
    );

    // Grant decision; last_q=1 means the core was granted last.
`ifdef IMEM_ARB_RR_EN
    assign pick_core = core_req & (~spi_req | ~last_q);
`else
    assign pick_core = core_req & ~spi_req;
`endif

    // RAM FSM: grant, let the RAM sample, then return read data.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rwn_d   = rwn_q;
        done    = 1'b0;
        load    = 1'b0;
`ifdef IMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (spi_req | core_req) begin
                    gnt_d   = pick_core;
                    addr_d  = pick_core ? core_addr : spi_addr;
                    wdata_d = pick_core ? imem_hwdata : spi_hwdata;
                    rwn_d   = ~(pick_core ? core_wr : spi_wr);
                    state_d = ARB_ACCESS;
`ifdef IMEM_ARB_RR_EN
                    last_d  = pick_core;
`endif
                end
            end
            ARB_ACCESS: begin
                if (!rwn_q) begin
                    rwn_d   = 1'b1;
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_RDATA;
                end
            end
            ARB_RDATA: begin
                done    = 1'b1;
                load    = 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM and RAM control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rwn_q   <= 1'b1;
`ifdef IMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rwn_q   <= rwn_d;
`ifdef IMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign inst_addr  = addr_q;
    assign inst_write = wdata_q;
    assign inst_rwn   = rwn_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a registered-read RAM model.
// Define IMEM_ARB_RR_EN for both RTL and bench to test round-robin.
module tb_imem_arbiter;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] spi_haddr, spi_hwdata, spi_hrdata;
    logic        spi_hwrite, spi_hready, spi_hresp;
    logic [2:0]  spi_hsize;
    logic [1:0]  spi_htrans;
    logic [31:0] imem_haddr, imem_hwdata, imem_hrdata;
    logic        imem_hwrite, imem_hready, imem_hresp;
    logic [2:0]  imem_hsize;
    logic [1:0]  imem_htrans;
    logic [31:0] inst_read, inst_write;
    logic [13:0] inst_addr;
    logic        inst_rwn;

    logic [31:0] mem [0:16383];
    logic        pre_en;
    logic [13:0] pre_a;
    logic [31:0] pre_d;

    int n_vec = 0;
    int n_err = 0;

    imem_arbiter #(.ADDR_W(14)) dut (
        .clk(clk), .reset(reset),
        .spi_haddr(spi_haddr), .spi_hwrite(spi_hwrite),
        .spi_hsize(spi_hsize), .spi_htrans(spi_htrans),
        .spi_hwdata(spi_hwdata), .spi_hrdata(spi_hrdata),
        .spi_hready(spi_hready), .spi_hresp(spi_hresp),
        .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite),
        .imem_hsize(imem_hsize), .imem_htrans(imem_htrans),
        .imem_hwdata(imem_hwdata), .imem_hrdata(imem_hrdata),
        .imem_hready(imem_hready), .imem_hresp(imem_hresp),
        .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_write(inst_write), .inst_rwn(inst_rwn)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write on rwn=0, read data one cycle later.
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (!inst_rwn) mem[inst_addr] <= inst_write;
        inst_read <= mem[inst_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic spi_ap(input logic [31:0] a, input logic w,
                          input logic [2:0] sz);
        spi_haddr  = a;
        spi_hwrite = w;
        spi_hsize  = sz;
        spi_htrans = HTRANS_NONSEQ;
    endtask

    task automatic core_ap(input logic [31:0] a, input logic w,
                           input logic [2:0] sz);
        imem_haddr  = a;
        imem_hwrite = w;
        imem_hsize  = sz;
        imem_htrans = HTRANS_NONSEQ;
    endtask

    logic        core_first;
    logic [31:0] seq_exp [0:2];
    int          d, a;

    initial begin
        reset = 1'b1;
        pre_en = 1'b0; pre_a = '0; pre_d = '0;
        spi_haddr = '0; spi_hwrite = 1'b0; spi_hsize = HSIZE_WORD;
        spi_htrans = HTRANS_IDLE; spi_hwdata = '0;
        imem_haddr = '0; imem_hwrite = 1'b0; imem_hsize = HSIZE_WORD;
        imem_htrans = HTRANS_IDLE; imem_hwdata = '0;
`ifdef IMEM_ARB_RR_EN
        core_first = 1'b1;
`else
        core_first = 1'b0;
`endif
        tick(); tick();
        chk("rst_spi_rdy", {31'd0, spi_hready}, 32'd1);
        chk("rst_core_rdy", {31'd0, imem_hready}, 32'd1);
        chk("rst_resp", {30'd0, spi_hresp, imem_hresp}, 32'd0);
        chk("rst_spi_rdata", spi_hrdata, 32'd0);
        chk("rst_core_rdata", imem_hrdata, 32'd0);
        chk("rst_addr", {18'd0, inst_addr}, 32'd0);
        chk("rst_wdata", inst_write, 32'd0);
        chk("rst_rwn", {31'd0, inst_rwn}, 32'd1);
        reset = 1'b0;
        tick();

        // SPI write 0xDEADBEEF to 0x10
        spi_ap(32'h10, 1'b1, HSIZE_WORD);
        tick();
        spi_htrans = HTRANS_IDLE;
        spi_hwdata = 32'hDEADBEEF;
        chk("wr_c1_rdy", {31'd0, spi_hready}, 32'd0);
        chk("wr_c1_rwn", {31'd0, inst_rwn}, 32'd1);
        tick();
        chk("wr_c2_rdy", {31'd0, spi_hready}, 32'd0);
        chk("wr_c2_addr", {18'd0, inst_addr}, 32'd4);
        chk("wr_c2_rwn", {31'd0, inst_rwn}, 32'd0);
        chk("wr_c2_data", inst_write, 32'hDEADBEEF);
        tick();
        chk("wr_c3_rdy", {31'd0, spi_hready}, 32'd1);
        chk("wr_c3_rwn", {31'd0, inst_rwn}, 32'd1);
        chk("wr_c3_resp", {31'd0, spi_hresp}, 32'd0);

        // SPI read of 0x10 issued in the write's completion cycle
        spi_ap(32'h10, 1'b0, HSIZE_WORD);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) spi_htrans = HTRANS_IDLE;
            chk($sformatf("rd_c%0d_rdy", k), {31'd0, spi_hready}, 32'd0);
            chk($sformatf("rd_c%0d_rwn", k), {31'd0, inst_rwn}, 32'd1);
        end
        tick();
        chk("rd_c4_rdy", {31'd0, spi_hready}, 32'd1);
        chk("rd_c4_data", spi_hrdata, 32'hDEADBEEF);

        // Core read at the top word of the window
        preload(14'h3FFF, 32'h12345678);
        core_ap(32'h0000_FFFC, 1'b0, HSIZE_WORD);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) imem_htrans = HTRANS_IDLE;
            if (k == 2) chk("top_addr", {18'd0, inst_addr}, 32'h3FFF);
            chk($sformatf("top_c%0d_rdy", k), {31'd0, imem_hready}, 32'd0);
        end
        tick();
        chk("top_c4_rdy", {31'd0, imem_hready}, 32'd1);
        chk("top_c4_data", imem_hrdata, 32'h12345678);

        // Conflict: SPI write 0x20 and core read 0x10 together
        spi_ap(32'h20, 1'b1, HSIZE_WORD);
        core_ap(32'h10, 1'b0, HSIZE_WORD);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                spi_htrans  = HTRANS_IDLE;
                imem_htrans = HTRANS_IDLE;
                spi_hwdata  = 32'hA5A5A5A5;
            end
            if (k == 2) begin
                chk("cf_c2_addr", {18'd0, inst_addr}, 32'd8);
                chk("cf_c2_rwn", {31'd0, inst_rwn}, 32'd0);
                chk("cf_c2_data", inst_write, 32'hA5A5A5A5);
            end
            if (k == 4) begin
                chk("cf_c4_addr", {18'd0, inst_addr}, 32'd4);
                chk("cf_c4_rwn", {31'd0, inst_rwn}, 32'd1);
            end
            chk($sformatf("cf_c%0d_spi", k), {31'd0, spi_hready},
                {31'd0, k >= 3});
            chk($sformatf("cf_c%0d_core", k), {31'd0, imem_hready},
                {31'd0, k >= 6});
        end
        chk("cf_core_data", imem_hrdata, 32'hDEADBEEF);

        // SPI-only read of 0x20, then a second conflict of two reads
        spi_ap(32'h20, 1'b0, HSIZE_WORD);
        tick();
        spi_htrans = HTRANS_IDLE;
        tick(); tick(); tick();
        chk("pre_rd_rdy", {31'd0, spi_hready}, 32'd1);
        chk("pre_rd_data", spi_hrdata, 32'hA5A5A5A5);
        spi_ap(32'h10, 1'b0, HSIZE_WORD);
        core_ap(32'h20, 1'b0, HSIZE_WORD);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                spi_htrans  = HTRANS_IDLE;
                imem_htrans = HTRANS_IDLE;
            end
            if (k == 2)
                chk("cf2_c2_addr", {18'd0, inst_addr},
                    core_first ? 32'd8 : 32'd4);
            chk($sformatf("cf2_c%0d_spi", k), {31'd0, spi_hready},
                {31'd0, core_first ? k >= 7 : k >= 4});
            chk($sformatf("cf2_c%0d_core", k), {31'd0, imem_hready},
                {31'd0, core_first ? k >= 4 : k >= 7});
        end
        chk("cf2_spi_data", spi_hrdata, 32'hDEADBEEF);
        chk("cf2_core_data", imem_hrdata, 32'hA5A5A5A5);

        // Error responses: out of window, byte size, misaligned
        for (int e = 0; e < 3; e++) begin
            if (e == 0) core_ap(32'h0001_0000, 1'b0, HSIZE_WORD);
            if (e == 1) spi_ap(32'h4, 1'b1, 3'b000);
            if (e == 2) spi_ap(32'h2, 1'b0, HSIZE_WORD);
            for (int k = 1; k <= 3; k++) begin
                tick();
                if (k == 1) begin
                    spi_htrans  = HTRANS_IDLE;
                    imem_htrans = HTRANS_IDLE;
                end
                chk($sformatf("err%0d_c%0d_rdy", e, k),
                    {31'd0, (e == 0) ? imem_hready : spi_hready},
                    {31'd0, k >= 2});
                chk($sformatf("err%0d_c%0d_resp", e, k),
                    {31'd0, (e == 0) ? imem_hresp : spi_hresp},
                    {31'd0, k <= 2});
                chk($sformatf("err%0d_c%0d_rwn", e, k),
                    {31'd0, inst_rwn}, 32'd1);
            end
        end

        // Pipelined SEQ core reads of 0x0, 0x4, 0x8
        seq_exp[0] = 32'h11111111;
        seq_exp[1] = 32'h22222222;
        seq_exp[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) preload(14'(i), seq_exp[i]);
        core_ap(32'h0, 1'b0, HSIZE_WORD);
        tick();
        imem_haddr  = 32'h4;
        imem_htrans = HTRANS_SEQ;
        d = 0;
        a = 2;
        for (int cyc = 0; cyc < 40 && d < 3; cyc++) begin
            if (imem_hready) begin
                chk($sformatf("seq_%0d", d), imem_hrdata, seq_exp[d]);
                d++;
                tick();
                if (a < 3) begin
                    imem_haddr = 32'(a * 4);
                    a++;
                end else begin
                    imem_htrans = HTRANS_IDLE;
                end
            end else begin
                tick();
            end
        end
        chk("seq_count", 32'(d), 32'd3);

        // Reset during a pending SPI write
        spi_ap(32'h30, 1'b1, HSIZE_WORD);
        tick();
        spi_htrans = HTRANS_IDLE;
        spi_hwdata = 32'h0BADF00D;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_rdy", {31'd0, spi_hready}, 32'd1);
        chk("mr_rwn", {31'd0, inst_rwn}, 32'd1);
        chk("mr_addr", {18'd0, inst_addr}, 32'd0);
        chk("mr_wdata", inst_write, 32'd0);
        chk("mr_rdata", spi_hrdata, 32'd0);
        chk("mr_core_rdata", imem_hrdata, 32'd0);
        tick();
        spi_ap(32'h20, 1'b0, HSIZE_WORD);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) spi_htrans = HTRANS_IDLE;
            chk($sformatf("post_c%0d_rdy", k), {31'd0, spi_hready},
                {31'd0, k == 4});
        end
        chk("post_data", spi_hrdata, 32'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
